// File: rtl/riscv_fetch_aligner_if.sv
// Fetch aligner handshake bundle.
// Upstream word stream in, aligned instruction stream out.
interface riscv_fetch_aligner_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  in_valid_i;
  logic                  in_ready_o;
  logic [31:0]           in_rdata_i;
  logic [ADDR_WIDTH-1:0] in_addr_i;
  logic                  out_valid_o;
  logic                  out_ready_i;
  logic [31:0]           out_rdata_o;
  logic [ADDR_WIDTH-1:0] out_addr_o;
  logic                  out_is_compressed_o;

  modport master (
    output in_valid_i, in_rdata_i, in_addr_i,
    output out_ready_i,
    input  in_ready_o,
    input  out_valid_o, out_rdata_o, out_addr_o,
    input  out_is_compressed_o
  );

  modport slave (
    input  in_valid_i, in_rdata_i, in_addr_i,
    input  out_ready_i,
    output in_ready_o,
    output out_valid_o, out_rdata_o, out_addr_o,
    output out_is_compressed_o
  );
endinterface

// File: rtl/riscv_fetch_aligner.sv
// Fetch word buffer with halfword instruction aligner.
// Handles compressed and word-straddling 32-bit instructions.
module riscv_fetch_aligner #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         branch_i,
  input  logic [ADDR_WIDTH-1:0]        branch_addr_i,
  riscv_fetch_aligner_if.slave         bus,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy_o,
  output logic                         busy_o
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int AW = ADDR_WIDTH;

  logic [31:0]   mem_data [DEPTH];
  logic [AW-1:0] mem_addr [DEPTH];

  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] nx_ptr;
  logic [CW-1:0] count;
  logic          offset;

  logic [31:0]   head;
  logic [15:0]   nxt_lo;
  logic [15:0]   hw;
  logic          is32;
  logic          empty;
  logic          out_valid;
  logic [31:0]   rdata;
  logic [AW-1:0] addr;
  logic          fire;
  logic          pop;
  logic          push;
  logic          in_ready;
  logic          unused_bits;

  assign unused_bits = ^{branch_addr_i[AW-1:2], branch_addr_i[0]};

  // Decode the instruction sitting at the current halfword offset
  always_comb begin
    nx_ptr    = rd_ptr + PW'(1);
    head      = mem_data[rd_ptr];
    nxt_lo    = mem_data[nx_ptr][15:0];
    hw        = offset ? head[31:16] : head[15:0];
    is32      = (hw[1:0] == 2'b11);
    empty     = (count == '0);
    out_valid = !empty &&
                !(offset && is32 && count < CW'(2));
    rdata     = '0;
    addr      = '0;
    if (!empty) begin
      unique case (1'b1)
        !is32:           rdata = {16'h0, hw};
        is32 && !offset: rdata = head;
        is32 && offset:  rdata = {nxt_lo, head[31:16]};
      endcase
      addr = mem_addr[rd_ptr] +
             {{(AW-2){1'b0}}, offset, 1'b0};
    end
  end

  assign in_ready = (count != CW'(DEPTH));
  assign fire     = out_valid && bus.out_ready_i;
  assign pop      = fire && (offset || is32);
  assign push     = bus.in_valid_i && in_ready && !branch_i;

  assign bus.in_ready_o          = in_ready;
  assign bus.out_valid_o         = out_valid;
  assign bus.out_rdata_o         = rdata;
  assign bus.out_addr_o          = addr;
  assign bus.out_is_compressed_o = (rdata[1:0] != 2'b11);
  assign occupancy_o             = count;
  assign busy_o                  = !empty;

  // Pointer, count and halfword offset bookkeeping; branch wins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      offset <= 1'b0;
    end else if (branch_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      offset <= branch_addr_i[1];
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= nx_ptr;
      count <= count + CW'(push) - CW'(pop);
      if (fire && !is32) offset <= ~offset;
    end
  end

  // Word storage; contents only matter under a valid count
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= bus.in_rdata_i;
      mem_addr[wr_ptr] <= bus.in_addr_i;
    end
  end
endmodule

// File: tb/tb_riscv_fetch_aligner.sv
// Bench for riscv_fetch_aligner.
// Halfword-queue reference model, directed then random stimulus.
module tb_riscv_fetch_aligner;
  localparam int DEPTH = 4;
  localparam int AW    = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          br = 1'b0;
  logic [AW-1:0] br_addr = '0;
  logic [2:0]    occ;
  logic          busy;

  riscv_fetch_aligner_if #(.ADDR_WIDTH(AW)) bus();

  riscv_fetch_aligner #(
    .DEPTH(DEPTH),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .branch_i(br),
    .branch_addr_i(br_addr),
    .bus(bus),
    .occupancy_o(occ),
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  task automatic chk(string tag, logic [63:0] got,
                     logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [15:0] h;
    logic [31:0] a;
    int          id;
  } hw_t;

  hw_t         hq[$];
  int          wid  = 0;
  bit          skip = 0;
  logic [31:0] pc   = '0;

  function automatic int m_occ();
    if (hq.size() == 0) return 0;
    return hq[$].id - hq[0].id + 1;
  endfunction

  function automatic bit m_valid();
    if (hq.size() == 0) return 0;
    if (hq[0].h[1:0] != 2'b11) return 1;
    return hq.size() >= 2;
  endfunction

  task automatic check_out();
    logic [31:0] ed;
    chk("occ", occ, m_occ());
    chk("busy", busy, m_occ() != 0);
    chk("in_ready", bus.in_ready_o, m_occ() != DEPTH);
    chk("valid", bus.out_valid_o, m_valid());
    if (hq.size() == 0) begin
      chk("empty_data", bus.out_rdata_o, 0);
      chk("empty_addr", bus.out_addr_o, 0);
    end else if (m_valid()) begin
      if (hq[0].h[1:0] != 2'b11) ed = {16'h0, hq[0].h};
      else ed = {hq[1].h, hq[0].h};
      chk("data", bus.out_rdata_o, ed);
      chk("addr", bus.out_addr_o, hq[0].a);
      chk("is_c", bus.out_is_compressed_o,
          hq[0].h[1:0] != 2'b11);
    end
  endtask

  task automatic model_step();
    int o;
    bit v;
    hw_t e;
    o = m_occ();
    v = m_valid();
    if (br) begin
      hq.delete();
      skip = br_addr[1];
      pc   = {br_addr[31:2], 2'b00};
    end else begin
      if (v && bus.out_ready_i) begin
        if (hq[0].h[1:0] == 2'b11) void'(hq.pop_front());
        void'(hq.pop_front());
      end
      if (bus.in_valid_i && o != DEPTH) begin
        e.id = wid;
        if (!skip) begin
          e.h = bus.in_rdata_i[15:0];
          e.a = bus.in_addr_i;
          hq.push_back(e);
        end
        e.h = bus.in_rdata_i[31:16];
        e.a = bus.in_addr_i + 2;
        hq.push_back(e);
        wid++;
        skip = 0;
        pc   = pc + 4;
      end
    end
  endtask

  task automatic cyc(bit b, logic [31:0] ba, bit iv,
                     logic [31:0] d, logic [31:0] a, bit rdy);
    @(negedge clk);
    check_out();
    br              = b;
    br_addr         = ba;
    bus.in_valid_i  = iv;
    bus.in_rdata_i  = d;
    bus.in_addr_i   = a;
    bus.out_ready_i = rdy;
    @(posedge clk);
    model_step();
  endtask

  function automatic logic [15:0] rhw();
    logic [15:0] h;
    h = 16'($urandom);
    if ($urandom_range(0, 1) == 1) h[1:0] = 2'b11;
    else if (h[1:0] == 2'b11) h[1:0] = 2'b01;
    return h;
  endfunction

  bit          rb;
  logic [31:0] rba;
  logic [31:0] rd;

  initial begin
    bus.in_valid_i  = 1'b0;
    bus.in_rdata_i  = '0;
    bus.in_addr_i   = '0;
    bus.out_ready_i = 1'b0;
    repeat (2) @(negedge clk);
    check_out();
    rst = 1'b0;

    cyc(0, 0, 1, 32'h0000_0013, 32'h100, 1);
    #1 chk("t1_d0", bus.out_rdata_o, 32'h13);
    chk("t1_c0", bus.out_is_compressed_o, 0);
    cyc(0, 0, 1, 32'h0010_0093, 32'h104, 1);
    #1 chk("t1_d1", bus.out_rdata_o, 32'h0010_0093);
    chk("t1_a1", bus.out_addr_o, 32'h104);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    #1 chk("t1_occ", occ, 0);

    cyc(0, 0, 1, 32'h4501_4505, 32'h200, 0);
    #1 chk("t2_d0", bus.out_rdata_o, 32'h4505);
    chk("t2_c0", bus.out_is_compressed_o, 1);
    cyc(0, 0, 0, 0, 0, 1);
    #1 chk("t2_d1", bus.out_rdata_o, 32'h4501);
    chk("t2_a1", bus.out_addr_o, 32'h202);
    chk("t2_occ", occ, 1);
    cyc(0, 0, 0, 0, 0, 1);
    #1 chk("t2_occ0", occ, 0);

    cyc(1, 32'h302, 0, 0, 0, 0);
    cyc(0, 0, 1, 32'h0013_0001, 32'h300, 1);
    #1 chk("t3_v0", bus.out_valid_o, 0);
    chk("t3_occ", occ, 1);
    cyc(0, 0, 1, 32'hABCD_0093, 32'h304, 0);
    #1 chk("t3_d", bus.out_rdata_o, 32'h0093_0013);
    chk("t3_a", bus.out_addr_o, 32'h302);
    cyc(0, 0, 0, 0, 0, 1);
    #1 chk("t3_d2", bus.out_rdata_o, 32'h0000_ABCD);
    chk("t3_a2", bus.out_addr_o, 32'h306);
    cyc(0, 0, 0, 0, 0, 1);

    cyc(1, 32'h10, 0, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++)
      cyc(0, 0, 1, 32'h13 | (i << 20), 32'h10 + 4 * i, 0);
    #1 chk("t4_full_rdy", bus.in_ready_o, 0);
    chk("t4_full_occ", occ, 4);
    cyc(0, 0, 1, 32'h0050_0013, 32'h20, 1);
    #1 chk("t4_nopush", occ, 3);
    cyc(0, 0, 1, 32'h0050_0013, 32'h20, 0);
    #1 chk("t4_push", occ, 4);
    repeat (6) cyc(0, 0, 0, 0, 0, 1);

    cyc(1, 32'h0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      cyc(0, 0, 1, 32'h13, 4 * i, 0);
    cyc(1, 32'h40, 1, 32'h1111_1111, 32'hC, 0);
    #1 chk("t5_occ", occ, 0);
    chk("t5_v", bus.out_valid_o, 0);
    cyc(0, 0, 0, 0, 0, 0);

    cyc(1, 32'h502, 0, 0, 0, 0);
    cyc(0, 0, 1, 32'h0000_0013, 32'h500, 0);
    cyc(0, 0, 1, 32'h0000_0013, 32'h504, 0);
    @(negedge clk);
    check_out();
    bus.in_valid_i = 1'b0;
    #2 rst = 1'b1;
    #1 chk("t6_v", bus.out_valid_o, 0);
    chk("t6_occ", occ, 0);
    chk("t6_d", bus.out_rdata_o, 0);
    chk("t6_a", bus.out_addr_o, 0);
    chk("t6_rdy", bus.in_ready_o, 1);
    hq.delete();
    skip = 0;
    @(negedge clk);
    rst = 1'b0;
    cyc(0, 0, 1, 32'h0000_0013, 32'h400, 0);
    #1 chk("t6_a2", bus.out_addr_o, 32'h400);
    chk("t6_v2", bus.out_valid_o, 1);

    cyc(1, 32'h1000, 0, 0, 0, 0);
    repeat (3000) begin
      rb  = ($urandom_range(0, 49) == 0);
      rba = 32'h2000 + ($urandom_range(0, 1023) << 1);
      rd  = {rhw(), rhw()};
      cyc(rb, rba, $urandom_range(0, 3) != 0, rd, pc,
          $urandom_range(0, 2) != 0);
    end
    @(negedge clk);
    check_out();

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/riscv_fetch_aligner.md
Name: riscv_fetch_aligner

Overview:
- Parametrised fetch buffer and instruction aligner placed between the instruction prefetcher and the IF/ID pipeline registers.
- Stores up to DEPTH fetched 32-bit words with their addresses.
- Extracts 16-bit (compressed) and 32-bit instructions at any halfword alignment, including 32-bit instructions that straddle two words. The previous fetch path supports only word-aligned instructions.
- Flushes on branch and restarts at a halfword-aligned target.

Parameters:
- DEPTH, 4, number of 32-bit word entries; power of two, at least 2.
- ADDR_WIDTH, 32, address width of in_addr_i, branch_addr_i and out_addr_o.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- branch_i  input  1  flush the buffer and restart at branch_addr_i
- branch_addr_i  input  ADDR_WIDTH  restart address; bit 0 ignored, bit 1 selects the initial halfword offset
- in_valid_i  input  1  fetched word available
- in_ready_o  output  1  buffer can accept a word
- in_rdata_i  input  32  fetched word
- in_addr_i  input  ADDR_WIDTH  word-aligned address of in_rdata_i
- out_valid_o  output  1  complete instruction available
- out_ready_i  input  1  downstream consumes the instruction
- out_rdata_o  output  32  instruction; compressed instructions are zero-extended in bits [31:16]
- out_addr_o  output  ADDR_WIDTH  halfword address of the instruction
- out_is_compressed_o  output  1  out_rdata_o[1:0] != 2'b11
- occupancy_o  output  $clog2(DEPTH+1)  number of valid words held
- busy_o  output  1  occupancy_o != 0

Behaviour:
Reset (asynchronous, rst=1):
- count=0, rd/wr pointers=0, offset=0.
- out_valid_o=0, in_ready_o=1 once reset is released.
- out_rdata_o and out_addr_o read 0 while empty.

Storage:
- Circular FIFO of {word, addr}. Pointers wrap modulo DEPTH.
- in_ready_o = (count != DEPTH). There is no same-cycle bypass at full.
- Push occurs when in_valid_i && in_ready_o && !branch_i.
- Latency: a word pushed at edge N is visible at the output after edge N; first out_valid_o occurs in the cycle after the push.

Aligner:
- head = entry[rd], next = entry[rd+1].
- offset=0, head[1:0]!=11: compressed, data {16'h0, head[15:0]}, valid if count>=1.
- offset=0, head[1:0]==11: 32-bit, data head, valid if count>=1.
- offset=1, head[17:16]!=11: compressed, data {16'h0, head[31:16]}, valid if count>=1.
- offset=1, head[17:16]==11: misaligned 32-bit, data {next[15:0], head[31:16]}, valid only if count>=2.
- out_addr_o = head.addr + (offset ? 2 : 0).

Pop and offset update on out_valid_o && out_ready_i:
- offset0 compressed: offset<=1, no pop.
- offset0 32-bit: pop 1, offset stays 0.
- offset1 compressed: pop 1, offset<=0.
- offset1 32-bit: pop 1, offset stays 1.

Other rules:
- Simultaneous push and pop: count unchanged, both pointers advance.
- Outputs are a function of registered state only; no combinational path from in_* to out_*.
- Once asserted, out_valid_o, out_rdata_o and out_addr_o stay stable until consumed or branch_i.

Branch:
- branch_i=1 has priority over push and pop.
- Next cycle: count=0, pointers=0, offset<=branch_addr_i[1], out_valid_o=0.
- The word offered in the branch cycle is dropped.
- The first word pushed after a branch must be the word at {branch_addr_i[AW-1:2], 2'b00}. This is the upstream's responsibility.

Misc:
- out_ready_i with out_valid_o=0 has no effect.
- Reset asserted mid-operation clears all state immediately; any partially assembled instruction is discarded.

Test Plan:
- Reset, then push words 0x00000013@0x100 and 0x00100093@0x104, out_ready_i=1 -> out 0x00000013@0x100 (is_compressed=0), then 0x00100093@0x104; occupancy returns to 0.
- Push 0x45014505@0x200 -> out 0x00004505@0x200 compressed, then 0x00004501@0x202 compressed; one pop total.
- Branch to 0x302, then push 0x00130001@0x300 and 0xABCD0093@0x304 -> first out 0x00000013@0x302? No: head[17:16]=2'b11, so out 0x00930013@0x302 only after the second word arrives; out_valid_o=0 while count=1.
- Fill DEPTH=4 words with out_ready_i=0 -> in_ready_o=0 and occupancy_o=4; raise out_ready_i for 1 cycle while in_valid_i=1 -> no push that cycle, push in the following cycle; wrap-around order preserved.
- Assert branch_i with 3 words buffered and in_valid_i=1 -> next cycle occupancy_o=0, out_valid_o=0, the offered word is not stored.
- Assert rst with 2 words held and offset=1 -> all outputs reach reset values asynchronously; after release the next push at 0x400 produces out_addr_o=0x400.
